ram_port_arbiter: RTL and testbench

- Shares one port of the generic dual-port RAM between two single-clock requesters, m0 and m1.
- Typical pairing: CPU data bus on m0 and the debug/DMA master on m1, with RAM port B left to the other agent.
- Round-robin arbitration, optional bus lock with bounded hold time, and routing of the 1-cycle registered read data back to the issuing requester.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_port_arbiter_if.sv | 48 ++++
 rtl/ram_port_arbiter_rr_arb2.sv | 24 ++
 rtl/ram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RAM port arbiter.
//   arb_state_e  - arbiter FSM encoding (ARB = free arbitration, LOCKED = owner only)
//   M0 / M1      - requester index constants
//   lock_cnt_w() - width of the consecutive-locked-transfer counter
package ram_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Counter must be able to hold MAX_LOCK itself.
    function automatic int lock_cnt_w(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundle of the two requester ports and the shared RAM port.
//   mN_req/we/lock/addr/wdata  requester -> arbiter
//   mN_gnt/rvalid/rdata        arbiter -> requester
//   ram_we/addr/din            arbiter -> RAM
//   ram_dout                   RAM -> arbiter (registered, 1-cycle latency)
// Modports: master (requester side), slave (arbiter side), ram (RAM side).
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  m0_req, m0_we, m0_lock;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt, m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req, m1_we, m1_lock;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt, m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport ram (
        input  ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//   req_i  [1:0]  raw requests
//   mask_i [1:0]  eligibility (both set in ARB, owner only in LOCKED)
//   prio_i        preferred index on contention (0 = m0)
//   gnt_o  [1:0]  one-hot or zero grant
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);
    logic [1:0] elig;

    assign elig = req_i & mask_i;

    always_comb begin
        gnt_o = elig;
        if (elig == 2'b11) begin
            gnt_o = (prio_i == M1) ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between requesters m0 and m1.
//   clk, rst  single clock, synchronous active-high reset
//   bus       ram_port_arbiter_if.slave - requester ports and RAM port
// Round-robin arbitration, optional bus lock bounded to MAX_LOCK consecutive
// transfers, and routing of the 1-cycle registered read data to the issuer.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_LOCK   = 16
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus
);
    localparam int              LCW        = lock_cnt_w(MAX_LOCK);
    localparam logic [LCW-1:0]  MAX_LOCK_C = LCW'(MAX_LOCK);

    arb_state_e            state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  owner_q, owner_d;
    logic [LCW-1:0]        lock_cnt_q, lock_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [1:0]            req, mask, gnt;
    logic                  accept, gidx;
    logic                  sel_we, sel_lock, owner_req;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  rv;

    // Gating requests with rst forces both grants (and so ram_we) low in reset.
    assign req = rst ? 2'b00 : {bus.m1_req, bus.m0_req};

    always_comb begin
        mask = 2'b11;
        if (state_q == LOCKED) begin
            mask = (owner_q == M1) ? 2'b10 : 2'b01;
        end
    end

    rr_arb2 u_arb (
        .req_i  (req),
        .mask_i (mask),
        .prio_i (prio_q),
        .gnt_o  (gnt)
    );

    assign accept    = |gnt;
    assign gidx      = gnt[1] ? M1 : M0;
    assign sel_we    = (gidx == M1) ? bus.m1_we    : bus.m0_we;
    assign sel_lock  = (gidx == M1) ? bus.m1_lock  : bus.m0_lock;
    assign sel_addr  = (gidx == M1) ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = (gidx == M1) ? bus.m1_wdata : bus.m0_wdata;
    assign owner_req = (owner_q == M1) ? bus.m1_req : bus.m0_req;

    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];

    // Address holds its last granted value while idle to avoid toggling the RAM.
    assign bus.ram_we   = accept & sel_we;
    assign bus.ram_addr = accept ? sel_addr : addr_q;
    assign bus.ram_din  = sel_wdata;

    // A response still in flight when rst rises is suppressed immediately.
    assign rv            = rd_pend_q & ~rst;
    assign bus.m0_rvalid = rv & (rd_sel_q == M0);
    assign bus.m1_rvalid = rv & (rd_sel_q == M1);
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.ram_dout : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.ram_dout : '0;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        addr_d     = addr_q;
        rd_pend_d  = accept & ~sel_we;
        rd_sel_d   = rd_sel_q;

        if (accept) begin
            prio_d   = ~gidx;
            addr_d   = sel_addr;
            rd_sel_d = gidx;
        end

        case (state_q)
            ARB: begin
                if (accept && sel_lock && (MAX_LOCK > 1)) begin
                    state_d    = LOCKED;
                    owner_d    = gidx;
                    lock_cnt_d = LCW'(1);
                end
            end
            LOCKED: begin
                if (!owner_req) begin
                    // Idle owner forfeits the lock.
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (accept) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                    if (!sel_lock || (lock_cnt_q + LCW'(1) == MAX_LOCK_C)) begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            prio_q     <= M0;
            owner_q    <= M0;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_sel_q   <= M0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_sel_q   <= rd_sel_d;
            addr_q     <= addr_d;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vector bench for ram_port_arbiter with a
// write-first, 1-cycle registered RAM model attached to the shared port.
module tb_ram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int ML = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: write-first, registered output.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] dout_q;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        dout_q <= bus.ram_we ? bus.ram_din : mem[bus.ram_addr];
    end
    assign bus.ram_dout = dout_q;

    typedef struct {
        logic          rst;
        logic          r0, w0, l0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1, l1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0, g1, v0, v1;
        logic [DW-1:0] rd0, rd1;
        logic          rwe;
        logic [AW-1:0] raddr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs [$];

    function automatic vec_t mk(
        input logic rs,
        input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic g0, input logic g1, input logic v0, input logic v1,
        input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
        input logic rwe, input logic [AW-1:0] raddr);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.rd0 = rd0; v.rd1 = rd1; v.rwe = rwe; v.raddr = raddr;
        return v;
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        bus.m0_req   = v.r0; bus.m0_we = v.w0; bus.m0_lock = v.l0;
        bus.m0_addr  = v.a0; bus.m0_wdata = v.d0;
        bus.m1_req   = v.r1; bus.m1_we = v.w1; bus.m1_lock = v.l1;
        bus.m1_addr  = v.a1; bus.m1_wdata = v.d1;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0,0,0,'0,'0, 0,0,0,'0,'0, 0,0,0,0,'0,'0, 0,'0));
    endtask

    initial begin
        mem[10'h010] = 32'h11;
        mem[10'h020] = 32'h22;
        mem[10'h3FF] = 32'h3FF3FF;

        //          rst r0 w0 l0 a0      d0            r1 w1 l1 a1      d1    g0 g1 v0 v1 rd0           rd1      rwe raddr
        // reset with both requesting: no grants, no write
        vecs.push_back(mk(1, 1,1,0,10'h005,32'hDEADBEEF, 1,0,0,10'h020,'0,  0,0,0,0,'0,           '0,      0,10'h000));
        // m0 write then read of 0x005
        vecs.push_back(mk(0, 1,1,0,10'h005,32'hDEADBEEF, 0,0,0,'0,'0,       1,0,0,0,'0,           '0,      1,10'h005));
        vecs.push_back(mk(0, 1,0,0,10'h005,'0,           0,0,0,'0,'0,       1,0,0,0,'0,           '0,      0,10'h005));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                0,0,0,'0,'0,       0,0,1,0,32'hDEADBEEF, '0,      0,10'h005));
        // continuous contention: prio=1 after m0's last transfer, so m1 leads
        vecs.push_back(mk(0, 1,0,0,10'h010,'0,           1,0,0,10'h020,'0,  0,1,0,0,'0,           '0,      0,10'h020));
        vecs.push_back(mk(0, 1,0,0,10'h010,'0,           1,0,0,10'h020,'0,  1,0,0,1,'0,           32'h22,  0,10'h010));
        vecs.push_back(mk(0, 1,0,0,10'h010,'0,           1,0,0,10'h020,'0,  0,1,1,0,32'h11,       '0,      0,10'h020));
        vecs.push_back(mk(0, 1,0,0,10'h010,'0,           1,0,0,10'h020,'0,  1,0,0,1,'0,           32'h22,  0,10'h010));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                0,0,0,'0,'0,       0,0,1,0,32'h11,       '0,      0,10'h010));
        // m0 write 0xA5 -> m1 read same address next cycle
        vecs.push_back(mk(0, 1,1,0,10'h001,32'hA5,       0,0,0,'0,'0,       1,0,0,0,'0,           '0,      1,10'h001));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                1,0,0,10'h001,'0,  0,1,0,0,'0,           '0,      0,10'h001));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                0,0,0,'0,'0,       0,0,0,1,'0,           32'hA5,  0,10'h001));
        // m0 locks, drops req for one cycle, m1 then granted
        vecs.push_back(mk(0, 1,0,1,10'h010,'0,           1,0,0,10'h020,'0,  1,0,0,0,'0,           '0,      0,10'h010));
        vecs.push_back(mk(0, 1,0,1,10'h010,'0,           1,0,0,10'h020,'0,  1,0,1,0,32'h11,       '0,      0,10'h010));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                1,0,0,10'h020,'0,  0,0,1,0,32'h11,       '0,      0,10'h010));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                1,0,0,10'h020,'0,  0,1,0,0,'0,           '0,      0,10'h020));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                0,0,0,'0,'0,       0,0,0,1,'0,           32'h22,  0,10'h020));
        // m0 read 0x3FF, reset next cycle drops the response; prio back to m0
        vecs.push_back(mk(0, 1,0,0,10'h3FF,'0,           0,0,0,'0,'0,       1,0,0,0,'0,           '0,      0,10'h3FF));
        vecs.push_back(mk(1, 1,0,0,10'h010,'0,           1,0,0,10'h020,'0,  0,0,0,0,'0,           '0,      0,10'h3FF));
        vecs.push_back(mk(0, 1,0,0,10'h010,'0,           1,0,0,10'h020,'0,  1,0,0,0,'0,           '0,      0,10'h010));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                1,0,0,10'h020,'0,  0,1,1,0,32'h11,       '0,      0,10'h020));
        vecs.push_back(mk(0, 0,0,0,'0,'0,                0,0,0,'0,'0,       0,0,0,1,'0,           32'h22,  0,10'h020));

        // One unchecked reset cycle so every register is defined.
        drive(mk(1, 0,0,0,'0,'0, 0,0,0,'0,'0, 0,0,0,0,'0,'0, 0,'0));
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d m0_gnt", i),    DW'(bus.m0_gnt),    DW'(vecs[i].g0));
            check($sformatf("v%0d m1_gnt", i),    DW'(bus.m1_gnt),    DW'(vecs[i].g1));
            check($sformatf("v%0d m0_rvalid", i), DW'(bus.m0_rvalid), DW'(vecs[i].v0));
            check($sformatf("v%0d m1_rvalid", i), DW'(bus.m1_rvalid), DW'(vecs[i].v1));
            check($sformatf("v%0d ram_we", i),    DW'(bus.ram_we),    DW'(vecs[i].rwe));
            check($sformatf("v%0d ram_addr", i),  DW'(bus.ram_addr),  DW'(vecs[i].raddr));
            if (vecs[i].v0) check($sformatf("v%0d m0_rdata", i), bus.m0_rdata, vecs[i].rd0);
            if (vecs[i].v1) check($sformatf("v%0d m1_rdata", i), bus.m1_rdata, vecs[i].rd1);
            @(posedge clk); #1;
        end

        // m1 holds lock for reads (m1 alone on cycle 0, m0 contending after):
        // exactly MAX_LOCK consecutive m1 grants, then m0.
        for (int c = 0; c <= ML; c++) begin
            drive(mk(0, (c > 0),0,0,10'h010,'0, 1,0,1,10'h020,'0, 0,0,0,0,'0,'0, 0,'0));
            @(negedge clk);
            check($sformatf("lock c%0d m0_gnt", c),    DW'(bus.m0_gnt),    DW'(c == ML));
            check($sformatf("lock c%0d m1_gnt", c),    DW'(bus.m1_gnt),    DW'(c < ML));
            check($sformatf("lock c%0d m1_rvalid", c), DW'(bus.m1_rvalid), DW'(c >= 1));
            check($sformatf("lock c%0d m0_rvalid", c), DW'(bus.m0_rvalid), '0);
            if (c >= 1) check($sformatf("lock c%0d m1_rdata", c), bus.m1_rdata, 32'h22);
            @(posedge clk); #1;
        end
        drive_idle();
        @(negedge clk);
        check("lock tail m0_rvalid", DW'(bus.m0_rvalid), 32'h1);
        check("lock tail m0_rdata",  bus.m0_rdata,       32'h11);
        check("lock tail m1_rvalid", DW'(bus.m1_rvalid), '0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
